dec3to8: RTL and testbench
==========================

# dec3to8

3-to-8 one-hot decoder with active-high enable, built as two independent implementations and compared every cycle. The shift form computes `8'b1 << in`; the case form uses an 8-way case table. Both results are registered. A sticky mismatch flag catches any divergence. The block serves as the decode stage feeding one-hot select lines to downstream muxes and enables, and as a self-checking reference for decoder style comparisons.

## Interface
- `OUT_REG`, default 1: 1 = outputs registered (1-cycle latency); 0 = outputs combinational, bypassing the output registers. The mismatch flag is always registered.
- `clk` input 1: single clock; all state updates on its rising edge.
- `rst` input 1: reset, synchronous and active-high.
- `en` input 1: decode enable; 0 forces all-zero outputs.
- `in` input 3: binary select, 0..7.
- `out_shift` output 8: one-hot result from the shift implementation.
- `out_case` output 8: one-hot result from the case implementation.
- `mismatch` output 1: sticky flag; 1 once `out_shift` != `out_case` has been sampled.

## Operation
- en=1: bit `in` of each output is 1, all other bits 0.
  - in=0 gives 8'b0000_0001.
  - in=7 gives 8'b1000_0000.
- en=0: both outputs are 8'h00 for every value of `in`.
- Shift path: `({7'b0, en} << in)`, or equivalently en-gated `8'b1 << in`. No table lookup.
- Case path: explicit case on `in` with all 8 items plus a default of 8'h00, gated by en.
- Any X/Z on `in` or `en` drives the case path to its default (8'h00). The shift path is not required to match in that situation.
- Compare: each cycle, raw combinational shift and case results are compared. Inequality sets `mismatch`, which holds until `rst`.
- Outputs are never multi-hot. With en=1 exactly one bit is set; with en=0 no bit is set.

## Timing
- OUT_REG=1: `en`/`in` sampled at rising edge N appear on `out_shift`/`out_case` after edge N, i.e. 1-cycle latency.
- OUT_REG=0: outputs follow inputs combinationally with zero latency.
- `mismatch` updates at the rising edge after the divergent inputs are applied.
- Reset: `rst` high at a rising edge clears `out_shift`=8'h00, `out_case`=8'h00, `mismatch`=0.
  - Reset takes priority over new input data on the same edge.
  - Reset mid-operation discards the pending decode.
- First edge after `rst` deasserts: outputs reflect the `en`/`in` sampled at that edge.
- Back-to-back input changes every cycle are fully supported. There are no stalls or handshakes.

## Structure
- Sub-module `dec3to8_shift`: ports `out`[7:0], `in`[2:0], `en`. Purely combinational.
- Sub-module `dec3to8_case`: ports `out`[7:0], `in`[2:0], `en`. Purely combinational.
- Top `dec3to8` instantiates both sub-modules. It adds the output registers (generate on OUT_REG), the comparator and the sticky flag.
- Shared package `dec_pkg` holds:
  - `localparam SEL_W = 3`, `OUT_W = 8`;
  - the typedef for the one-hot output vector;
  - `ONEHOT_NONE = 8'h00`.

## Test plan
- Reset: hold `rst`=1 for 2 cycles with en=1, in=5 → outputs 8'h00 and mismatch=0 during reset. On the first edge after release, outputs = 8'h20.
- Disabled sweep: en=0, in=0..7 one per cycle → both outputs 8'h00 every cycle, mismatch=0.
- Enabled sweep: en=1, in=0..7 one per cycle → outputs 8'h01, 02, 04, 08, 10, 20, 40, 80, one cycle after each input (OUT_REG=1). `out_shift` == `out_case` throughout.
- Full 16-combination sweep of {en,in}, 4'b0000..4'b1111:
  - first 8 give 8'h00;
  - last 8 give the one-hot values above;
  - mismatch stays 0.
- Enable toggling: in=3 fixed, en toggling 1/0 each cycle → outputs alternate 8'h08/8'h00 with 1-cycle lag. With OUT_REG=0 the alternation has no lag.
- Mismatch sticky: force a fault on the case path output (bench force) for one cycle → mismatch=1 the next cycle and stays 1 after release. A `rst` pulse clears it to 0.

Source files
------------

// File: rtl/dec_pkg.sv
// rtl/dec_pkg.sv - shared widths, one-hot type and constants for the 3-to-8 decoder
package dec_pkg;
    localparam int SEL_W = 3;
    localparam int OUT_W = 8;

    typedef logic [OUT_W-1:0] onehot_t;

    localparam onehot_t ONEHOT_NONE = 8'h00;
endpackage

// File: rtl/dec3to8_case.sv
// rtl/dec3to8_case.sv - case-table decoder; unknown select or enable falls to all-zero
module dec3to8_case
    import dec_pkg::*;
(
    output onehot_t          out,
    input  logic [SEL_W-1:0] in,
    input  logic             en
);
    always_comb begin
        out = ONEHOT_NONE;
        if (en) begin
            case (in)
                3'd0:    out = 8'h01;
                3'd1:    out = 8'h02;
                3'd2:    out = 8'h04;
                3'd3:    out = 8'h08;
                3'd4:    out = 8'h10;
                3'd5:    out = 8'h20;
                3'd6:    out = 8'h40;
                3'd7:    out = 8'h80;
                default: out = ONEHOT_NONE;
            endcase
        end
    end
endmodule

// File: rtl/dec3to8_shift.sv
// rtl/dec3to8_shift.sv - shift-form decoder: en-gated one shifted left by the select
module dec3to8_shift
    import dec_pkg::*;
(
    output onehot_t          out,
    input  logic [SEL_W-1:0] in,
    input  logic             en
);
    assign out = onehot_t'({7'b0, en}) << in;
endmodule

// File: rtl/dec3to8.sv
// rtl/dec3to8.sv - dual-implementation 3-to-8 decoder with optional output registers and sticky mismatch
module dec3to8
    import dec_pkg::*;
#(
    parameter bit OUT_REG = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [SEL_W-1:0] in,
    output onehot_t          out_shift,
    output onehot_t          out_case,
    output logic             mismatch
);
    onehot_t shift_raw;
    onehot_t case_raw;
    logic    mismatch_d;
    logic    mismatch_q;

    dec3to8_shift u_shift (
        .out (shift_raw),
        .in  (in),
        .en  (en)
    );

    dec3to8_case u_case (
        .out (case_raw),
        .in  (in),
        .en  (en)
    );

    // Compare the raw decodes so a divergence is caught regardless of OUT_REG
    assign mismatch_d = mismatch_q | (shift_raw != case_raw);

    always_ff @(posedge clk) begin
        if (rst) begin
            mismatch_q <= 1'b0;
        end else begin
            mismatch_q <= mismatch_d;
        end
    end

    assign mismatch = mismatch_q;

    generate
        if (OUT_REG) begin : g_out_reg
            onehot_t shift_q;
            onehot_t case_q;

            always_ff @(posedge clk) begin
                if (rst) begin
                    shift_q <= ONEHOT_NONE;
                    case_q  <= ONEHOT_NONE;
                end else begin
                    shift_q <= shift_raw;
                    case_q  <= case_raw;
                end
            end

            assign out_shift = shift_q;
            assign out_case  = case_q;
        end else begin : g_out_comb
            assign out_shift = shift_raw;
            assign out_case  = case_raw;
        end
    endgenerate
endmodule

// File: tb/tb_dec3to8.sv
// tb/tb_dec3to8.sv - directed self-checking bench for registered and combinational dec3to8
module tb_dec3to8;
    logic       clk;
    logic       rst;
    logic       en;
    logic [2:0] sel;
    logic [7:0] r_shift, r_case, c_shift, c_case;
    logic       r_mis, c_mis;

    int checks;
    int errors;
    logic [7:0] prev_exp;
    logic [7:0] tbl [8];

    dec3to8 #(.OUT_REG(1'b1)) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .in        (sel),
        .out_shift (r_shift),
        .out_case  (r_case),
        .mismatch  (r_mis)
    );

    dec3to8 #(.OUT_REG(1'b0)) dut_comb (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .in        (sel),
        .out_shift (c_shift),
        .out_case  (c_case),
        .mismatch  (c_mis)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %02h expected %02h", tag, got, exp);
        end
    endtask

    task automatic step(input logic e, input logic [2:0] s);
        logic [7:0] exp;
        @(negedge clk);
        en  = e;
        sel = s;
        exp = e ? tbl[s] : 8'h00;
        #1;
        check("comb_shift", c_shift, exp);
        check("comb_case", c_case, exp);
        check("reg_lag", r_shift, prev_exp);
        @(posedge clk);
        #1;
        check("reg_shift", r_shift, exp);
        check("reg_case", r_case, exp);
        check("reg_mismatch", {7'b0, r_mis}, 8'h00);
        check("comb_mismatch", {7'b0, c_mis}, 8'h00);
        prev_exp = exp;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        tbl = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80};

        // Reset held two cycles with a live decode request on the inputs
        rst = 1'b1;
        en  = 1'b1;
        sel = 3'd5;
        for (int i = 0; i < 2; i++) begin
            @(posedge clk);
            #1;
            check("rst_shift", r_shift, 8'h00);
            check("rst_case", r_case, 8'h00);
            check("rst_mismatch", {7'b0, r_mis}, 8'h00);
        end
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("post_rst_shift", r_shift, 8'h20);
        check("post_rst_case", r_case, 8'h20);
        prev_exp = 8'h20;

        for (int i = 0; i < 8; i++) step(1'b0, 3'(i));
        for (int i = 0; i < 8; i++) step(1'b1, 3'(i));
        for (int i = 0; i < 16; i++) begin
            logic [3:0] v;
            v = 4'(i);
            step(v[3], v[2:0]);
        end
        for (int i = 0; i < 6; i++) step(i[0] == 1'b0, 3'd3);

        // Fault the case path for one cycle and confirm the flag is sticky
        @(negedge clk);
        en  = 1'b1;
        sel = 3'd2;
        force dut.case_raw = 8'h00;
        @(posedge clk);
        #1;
        check("mis_set", {7'b0, r_mis}, 8'h01);
        @(negedge clk);
        release dut.case_raw;
        @(posedge clk);
        #1;
        check("mis_sticky", {7'b0, r_mis}, 8'h01);
        check("mis_other_dut", {7'b0, c_mis}, 8'h00);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("mis_cleared", {7'b0, r_mis}, 8'h00);
        check("rst_again_shift", r_shift, 8'h00);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("mis_after_rst", {7'b0, r_mis}, 8'h00);
        check("resume_case", r_case, 8'h04);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
